// File: rtl/occ_port_arbiter.sv
// Round-robin arbiter that shares the single rom_Occ read port among N_REQ requesters.
// The grant is combinational. Read data and a one-hot valid strobe come back one cycle later.

module occ_arb_lane #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              gnt,
   input  logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] addr_sel,
   output logic              rvalid
);

   // The masked address lets the top build the ROM address with a plain OR-reduce.
   assign addr_sel = gnt ? addr : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rvalid <= 1'b0;
      else if (clear) rvalid <= 1'b0;
      else            rvalid <= gnt;
   end

endmodule

module occ_port_arbiter #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear_i,
   input  logic [N_REQ-1:0]        req_i,
   input  logic [N_REQ*ADDR_W-1:0] addr_i,
   output logic [N_REQ-1:0]        gnt_o,
   output logic [N_REQ-1:0]        rvalid_o,
   output logic [DATA_W-1:0]       rdata_o,
   output logic                    ce_rom_Occ_o,
   output logic [ADDR_W-1:0]       addr1_rom_Occ_o,
   input  logic [DATA_W-1:0]       data_1_i
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0]              rr_ptr;
   logic [PTR_W-1:0]              win;
   logic [PTR_W-1:0]              nxt_ptr;
   logic [PTR_W:0]                idx;
   logic                          found;
   logic [N_REQ-1:0]              gnt;
   logic [N_REQ-1:0][ADDR_W-1:0]  addr_sel;

   // Search rr_ptr, rr_ptr+1, ... The modulo is an explicit subtract, so N_REQ need not be a power of 2.
   always_comb begin
      gnt   = '0;
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
         if (idx >= (PTR_W+1)'(N_REQ)) idx = idx - (PTR_W+1)'(N_REQ);
         if (!found && req_i[idx[PTR_W-1:0]]) begin
            gnt[idx[PTR_W-1:0]] = 1'b1;
            win                 = idx[PTR_W-1:0];
            found               = 1'b1;
         end
      end
   end

   assign nxt_ptr      = (win == PTR_W'(N_REQ-1)) ? '0 : win + PTR_W'(1);
   assign gnt_o        = gnt;
   assign ce_rom_Occ_o = found;

   for (genvar k = 0; k < N_REQ; k++) begin : g_lane
      occ_arb_lane #(.ADDR_W(ADDR_W)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .clear    (clear_i),
         .gnt      (gnt[k]),
         .addr     (addr_i[k*ADDR_W +: ADDR_W]),
         .addr_sel (addr_sel[k]),
         .rvalid   (rvalid_o[k])
      );
   end

   always_comb begin
      addr1_rom_Occ_o = '0;
      for (int k = 0; k < N_REQ; k++) addr1_rom_Occ_o = addr1_rom_Occ_o | addr_sel[k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        rr_ptr <= '0;
      else if (clear_i)  rr_ptr <= '0;
      else if (found)    rr_ptr <= nxt_ptr;
   end

   // On clear the data register holds, because the response is being dropped rather than delivered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    rdata_o <= '0;
      else if (found && !clear_i)    rdata_o <= data_1_i;
   end

endmodule

// File: tb/tb_occ_port_arbiter.sv
// Directed bench for occ_port_arbiter with a combinational ROM model.
// Inputs change on the falling edge. Outputs are sampled 1 time unit later.

module tb_occ_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic [3:0]  req;
   logic [31:0] addr;
   logic [3:0]  gnt;
   logic [3:0]  rvalid;
   logic [31:0] rdata;
   logic        ce;
   logic [7:0]  addr1;
   logic [31:0] data1;

   int tests_run    = 0;
   int tests_failed = 0;

   function automatic logic [31:0] rom(input logic [7:0] a);
      return {a, ~a, a ^ 8'h5A, 8'hC3};
   endfunction

   assign data1 = rom(addr1);

   occ_port_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .clear_i         (clear),
      .req_i           (req),
      .addr_i          (addr),
      .gnt_o           (gnt),
      .rvalid_o        (rvalid),
      .rdata_o         (rdata),
      .ce_rom_Occ_o    (ce),
      .addr1_rom_Occ_o (addr1),
      .data_1_i        (data1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      req = 4'b1111;
      #2;
      tests_run++; if (rvalid !== 4'b0000) begin tests_failed++; $display("FAIL reset_rvalid got %b exp 0000", rvalid); end
      tests_run++; if (rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata got %h exp 0", rdata); end
      tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL reset_gnt got %b exp 0001", gnt); end
      tests_run++; if (ce !== 1'b1 || addr1 !== 8'h10) begin tests_failed++; $display("FAIL reset_rom got ce=%b addr=%h exp 1/10", ce, addr1); end
      @(negedge clk); rst_n = 1'b1; req = 4'b0000;
      @(negedge clk); req = 4'b1111; #1;
      tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL release_ptr got %b exp 0001", gnt); end
      req = 4'b0000;
   endtask

   task automatic test_single();
      @(negedge clk); addr[23:16] = 8'h3C; req = 4'b0100; #1;
      tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL single_gnt got %b exp 0100", gnt); end
      tests_run++; if (addr1 !== 8'h3C || ce !== 1'b1) begin tests_failed++; $display("FAIL single_rom got addr=%h ce=%b exp 3c/1", addr1, ce); end
      @(negedge clk); req = 4'b0000; #1;
      tests_run++; if (rvalid !== 4'b0100) begin tests_failed++; $display("FAIL single_rvalid got %b exp 0100", rvalid); end
      tests_run++; if (rdata !== rom(8'h3C)) begin tests_failed++; $display("FAIL single_rdata got %h exp %h", rdata, rom(8'h3C)); end
   endtask

   task automatic test_rotation();
      logic [3:0] eg, ev;
      logic [7:0] la;
      @(negedge clk); clear = 1'b1; req = 4'b0000; addr[23:16] = 8'h30;
      @(negedge clk); clear = 1'b0;
      for (int k = 0; k < 8; k++) begin
         req = 4'b1111; #1;
         eg = 4'b0001 << (k % 4);
         ev = (k == 0) ? 4'b0000 : 4'b0001 << ((k - 1) % 4);
         la = 8'h10 + 8'(((k + 3) % 4) * 16);
         tests_run++; if (gnt !== eg) begin tests_failed++; $display("FAIL rot_gnt[%0d] got %b exp %b", k, gnt, eg); end
         tests_run++; if (rvalid !== ev) begin tests_failed++; $display("FAIL rot_rvalid[%0d] got %b exp %b", k, rvalid, ev); end
         if (k > 0) begin
            tests_run++; if (rdata !== rom(la)) begin tests_failed++; $display("FAIL rot_rdata[%0d] got %h exp %h", k, rdata, rom(la)); end
         end
         @(negedge clk);
      end
      req = 4'b0000; #1;
      tests_run++; if (rvalid !== 4'b1000 || rdata !== rom(8'h40)) begin tests_failed++; $display("FAIL rot_last got %b/%h exp 1000/%h", rvalid, rdata, rom(8'h40)); end
   endtask

   task automatic test_fairness();
      logic [3:0] rs [4] = '{4'b0001, 4'b0001, 4'b1001, 4'b0001};
      logic [3:0] ge [4] = '{4'b0001, 4'b0001, 4'b1000, 4'b0001};
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
         req = rs[j]; #1;
         tests_run++; if (gnt !== ge[j]) begin tests_failed++; $display("FAIL fair_gnt[%0d] got %b exp %b", j, gnt, ge[j]); end
         if (j > 0) begin
            tests_run++; if (rvalid !== ge[j-1]) begin tests_failed++; $display("FAIL fair_rvalid[%0d] got %b exp %b", j, rvalid, ge[j-1]); end
         end
         @(negedge clk);
      end
      req = 4'b0000;
   endtask

   task automatic test_idle();
      @(negedge clk); req = 4'b0010; #1;
      tests_run++; if (gnt !== 4'b0010) begin tests_failed++; $display("FAIL idle_gnt got %b exp 0010", gnt); end
      @(negedge clk); req = 4'b0000; #1;
      tests_run++; if (rvalid !== 4'b0010 || rdata !== rom(8'h20)) begin tests_failed++; $display("FAIL idle_resp got %b/%h exp 0010/%h", rvalid, rdata, rom(8'h20)); end
      for (int j = 0; j < 3; j++) begin
         @(negedge clk); #1;
         tests_run++; if (rvalid !== 4'b0000 || rdata !== rom(8'h20)) begin tests_failed++; $display("FAIL idle_hold[%0d] got %b/%h exp 0000/%h", j, rvalid, rdata, rom(8'h20)); end
         tests_run++; if (ce !== 1'b0 || gnt !== 4'b0000 || addr1 !== 8'h00) begin tests_failed++; $display("FAIL idle_rom[%0d] got ce=%b gnt=%b addr=%h exp 0/0000/00", j, ce, gnt, addr1); end
      end
      req = 4'b1111; #1;
      tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL idle_ptr got %b exp 0100", gnt); end
      req = 4'b0000;
   endtask

   task automatic test_addr_change();
      @(negedge clk); req = 4'b0110; #1;
      tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL wait_gnt got %b exp 0100", gnt); end
      @(negedge clk); addr[15:8] = 8'h77; req = 4'b0010; #1;
      tests_run++; if (gnt !== 4'b0010 || addr1 !== 8'h77) begin tests_failed++; $display("FAIL wait_addr got %b/%h exp 0010/77", gnt, addr1); end
      @(negedge clk); req = 4'b0000; #1;
      tests_run++; if (rvalid !== 4'b0010 || rdata !== rom(8'h77)) begin tests_failed++; $display("FAIL wait_rdata got %b/%h exp 0010/%h", rvalid, rdata, rom(8'h77)); end
      addr[15:8] = 8'h20;
   endtask

   task automatic test_clear();
      @(negedge clk); req = 4'b1000; clear = 1'b1; #1;
      tests_run++; if (gnt !== 4'b1000) begin tests_failed++; $display("FAIL clr_gnt got %b exp 1000", gnt); end
      @(negedge clk); clear = 1'b0; req = 4'b0000; #1;
      tests_run++; if (rvalid !== 4'b0000 || rdata !== rom(8'h77)) begin tests_failed++; $display("FAIL clr_resp got %b/%h exp 0000/%h", rvalid, rdata, rom(8'h77)); end
      req = 4'b1111; #1;
      tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL clr_ptr got %b exp 0001", gnt); end
      req = 4'b0100; clear = 1'b1; #1;
      tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL clr2_gnt got %b exp 0100", gnt); end
      @(negedge clk); clear = 1'b0; req = 4'b1111; #1;
      tests_run++; if (rvalid !== 4'b0000 || gnt !== 4'b0001) begin tests_failed++; $display("FAIL clr2_ptr got %b/%b exp 0000/0001", rvalid, gnt); end
      req = 4'b0000;
   endtask

   task automatic test_reset_mid();
      @(negedge clk); req = 4'b0010;
      @(posedge clk); #1;
      tests_run++; if (rvalid !== 4'b0010 || rdata !== rom(8'h20)) begin tests_failed++; $display("FAIL mid_resp got %b/%h exp 0010/%h", rvalid, rdata, rom(8'h20)); end
      rst_n = 1'b0; #1;
      tests_run++; if (rvalid !== 4'b0000 || rdata !== 32'h0) begin tests_failed++; $display("FAIL mid_async got %b/%h exp 0000/0", rvalid, rdata); end
      req = 4'b0100; #1;
      tests_run++; if (gnt !== 4'b0100 || addr1 !== 8'h30) begin tests_failed++; $display("FAIL mid_gnt got %b/%h exp 0100/30", gnt, addr1); end
      @(negedge clk); rst_n = 1'b1; req = 4'b0000;
      @(negedge clk); #1;
      tests_run++; if (rvalid !== 4'b0000) begin tests_failed++; $display("FAIL mid_after got %b exp 0000", rvalid); end
   endtask

   initial begin
      rst_n = 1'b0;
      clear = 1'b0;
      req   = 4'b0000;
      addr  = {8'h40, 8'h30, 8'h20, 8'h10};
      test_reset();
      test_single();
      test_rotation();
      test_fairness();
      test_idle();
      test_addr_change();
      test_clear();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
